codificador_bcd: RTL and testbench
==================================

CODIFICADOR_BCD -- requirements
Module: codificador_bcd

Interface
REQ-001 The block SHALL have parameter W, default 10, giving the binary input width (fixed at 10 for this release).
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to convert value_in; sampled only in IDLE.
REQ-005 The block SHALL have port value_in, input, W, an unsigned binary value captured on the accepting edge.
REQ-006 The block SHALL have port bcd_out, output, 12, registered [hundreds][tens][units] in BCD, bits 11:8, 7:4 and 3:0.
REQ-007 The block SHALL have port busy, output, 1, high while a conversion is in progress (SHIFT state).
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking bcd_out as updated.
REQ-009 The block SHALL have port overflow, output, 1, registered with bcd_out; high when the captured value exceeds 999.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1, the block SHALL capture value_in into a shift register, clear the 4-bit shift counter, and go to SHIFT.
REQ-012 Each SHIFT cycle SHALL perform one double-dabble step: every BCD digit >= 5 gets +3 (thousands digit included), then the combined {thousands, BCD, binary} register shifts left one bit.
REQ-013 After the 10th shift, the block SHALL go to DONE and register bcd_out and overflow in the same edge.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-015 Latency: for start accepted at edge N, the block SHALL assert done and make bcd_out valid in the cycle after edge N+10; busy SHALL be high from after edge N through edge N+10.
REQ-016 The block SHALL ignore start in SHIFT and DONE, with no queuing and no effect on the running conversion.
REQ-017 bcd_out and overflow SHALL hold their last values until the next DONE, and SHALL be unaffected by value_in changes during conversion.
REQ-018 Every bcd_out nibble SHALL be in the range 0..9 for all inputs.
REQ-019 overflow SHALL be 1 if and only if the captured value is >= 1000 (0..1023 range).

Reset
REQ-020 While reset=1, the block SHALL force state IDLE, bcd_out=12'h000, busy=0, done=0, overflow=0, and clear the counter and shift register, regardless of clock.
REQ-021 A reset asserted mid-conversion SHALL discard the conversion; no done pulse SHALL follow its release.
REQ-022 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-023 The block SHALL use macro BCD_SATURATE_EN to select out-of-range behaviour.
REQ-024 With BCD_SATURATE_EN defined, the block SHALL set bcd_out=12'h999 for any value >= 1000.
REQ-025 Without BCD_SATURATE_EN, the block SHALL drop the thousands digit, so bcd_out holds value mod 1000 (1023 -> 12'h023).
REQ-026 overflow SHALL behave identically in both builds.

Structure
REQ-027 Shared package bcd_pkg SHALL hold the FSM state enum, BCD_MAX=999, the shift count constant 10 and the BCD digit typedef (4 bits).
REQ-028 The per-digit add-3 corrector (digit in, digit out, combinational) SHALL be the sub-module ajuste_bcd, instantiated once per digit.
REQ-029 The thousands digit SHALL exist internally only and SHALL never be a port.

Verification
REQ-030 value_in=0, start pulse -> done after 10 cycles, bcd_out=12'h000, overflow=0.
REQ-031 value_in=255 and 999 back-to-back, each started after done -> bcd_out=12'h255, then 12'h999; overflow=0; cycle count verified against REQ-015.
REQ-032 value_in=1023 -> overflow=1; bcd_out=12'h999 with BCD_SATURATE_EN, 12'h023 without.
REQ-033 Start with value 123, start held high and value_in=456 during SHIFT -> single done, bcd_out=12'h123, no second conversion.
REQ-034 Reset asserted at the 5th SHIFT cycle -> outputs zero immediately, no done pulse; a next conversion of 017 yields 12'h017.
REQ-035 Exhaustive sweep 0..1023 -> bcd_out matches the decimal model and every nibble is <= 9.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg -- shared definitions for the binary-to-BCD converter.
//   state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   bcd_digit_t : one 4-bit BCD digit
//   BCD_MAX     : largest value representable in three BCD digits
//   SHIFT_COUNT : number of double-dabble shifts per conversion
//   BCD_SAT_VAL : output code used for out-of-range values in saturating builds
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int          BCD_MAX     = 999;
  localparam int          SHIFT_COUNT = 10;
  localparam logic [11:0] BCD_SAT_VAL = 12'h999;

endpackage : bcd_pkg

// File: rtl/ajuste_bcd.sv
// -----------------------------------------------------------------------------
// ajuste_bcd -- double-dabble digit corrector (combinational).
// A digit of 5 or more gets +3 so that the following left shift carries
// correctly into the next decimal digit.
//   digit_i : BCD digit before correction
//   digit_o : corrected digit
// -----------------------------------------------------------------------------
module ajuste_bcd
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  // add-3 correction
  always_comb begin
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule : ajuste_bcd

// File: rtl/codificador_bcd.sv
// -----------------------------------------------------------------------------
// codificador_bcd -- sequential binary-to-BCD converter (double dabble).
// One shift per clock; a conversion takes 10 SHIFT cycles plus one DONE cycle.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   start    : conversion request, sampled only in IDLE
//   value_in : unsigned binary value, captured when start is accepted
//   bcd_out  : registered {hundreds, tens, units}
//   busy     : high during SHIFT
//   done     : one-cycle pulse when bcd_out is updated
//   overflow : captured value was >= 1000 (registered with bcd_out)
// Build option: define BCD_SATURATE_EN to force bcd_out to 999 on overflow;
// otherwise the thousands digit is dropped (value mod 1000).
// -----------------------------------------------------------------------------
module codificador_bcd
  import bcd_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] value_in,
  output logic [11:0]  bcd_out,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam int SW = 16 + W;  // {thousands, hundreds, tens, units, binary}

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [SW-1:0]  sreg_q;
  logic [SW-1:0]  sreg_d;
  logic [11:0]    bcd_q;
  logic           busy_q;
  logic           done_q;
  logic           ovf_q;

  bcd_digit_t     dig_s [4];   // 3 = thousands ... 0 = units
  bcd_digit_t     adj_s [4];
  logic [11:0]    bcd_res_s;
  logic           ovf_res_s;

  // Per-digit correctors, thousands digit included
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign dig_s[g] = sreg_q[W + 4*g +: 4];
    ajuste_bcd u_ajuste (
      .digit_i (dig_s[g]),
      .digit_o (adj_s[g])
    );
  end

  // Corrected register shifted left by one bit
  always_comb begin
    sreg_d = {adj_s[3], adj_s[2], adj_s[1], adj_s[0], sreg_q[W-1:0]} << 1;
  end

  // Result after the final shift; a non-zero thousands digit means >= 1000
  always_comb begin
    ovf_res_s = (sreg_d[SW-1 -: 4] != 4'd0);
`ifdef BCD_SATURATE_EN
    if (ovf_res_s) begin
      bcd_res_s = BCD_SAT_VAL;
    end else begin
      bcd_res_s = sreg_d[W +: 12];
    end
`else
    bcd_res_s = sreg_d[W +: 12];
`endif
  end

  // FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sreg_q  <= '0;
      bcd_q   <= 12'h000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sreg_q  <= {16'h0000, value_in};
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sreg_q <= sreg_d;
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'(SHIFT_COUNT - 1)) begin
            bcd_q   <= bcd_res_s;
            ovf_q   <= ovf_res_s;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd_out  = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule : codificador_bcd

// File: tb/tb_codificador_bcd.sv
// -----------------------------------------------------------------------------
// tb_codificador_bcd -- directed self-checking bench for codificador_bcd.
// -----------------------------------------------------------------------------
module tb_codificador_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  value_in;
  logic [11:0] bcd_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  codificador_bcd #(.W(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value_in (value_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: hundreds/tens/units of the value (or saturated)
  function automatic logic [11:0] model_bcd(input int v);
    int m, h, t, u;
`ifdef BCD_SATURATE_EN
    if (v >= 1000) return 12'h999;
`endif
    m = v % 1000;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    return {h[3:0], t[3:0], u[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full conversion with latency checks; called at posedge+1 in IDLE
  task automatic run(input int v, input bit full);
    start    = 1'b1;
    value_in = v[9:0];
    step();                                  // accepting edge N
    start = 1'b0;
    if (full) chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (9) step();                       // edges N+1..N+9
    if (full) begin
      chk("busy_before_last", {31'd0, busy}, 32'd1);
      chk("no_early_done", {31'd0, done}, 32'd0);
    end
    step();                                  // edge N+10
    chk("done_pulse", {31'd0, done}, 32'd1);
    if (full) chk("busy_low_in_done", {31'd0, busy}, 32'd0);
    chk($sformatf("bcd_%0d", v), {20'd0, bcd_out}, {20'd0, model_bcd(v)});
    chk($sformatf("ovf_%0d", v), {31'd0, overflow}, (v >= 1000) ? 32'd1 : 32'd0);
    step();                                  // back to IDLE
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    value_in = 10'd0;
    #12;
    chk("rst_bcd",  {20'd0, bcd_out}, 32'h000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Zero, then back-to-back 255 and 999
    run(0, 1'b1);
    run(255, 1'b1);
    run(999, 1'b1);
    // Out of range
    run(1023, 1'b1);
    run(1000, 1'b1);

    // Start held high, value_in changed during SHIFT
    start    = 1'b1;
    value_in = 10'd123;
    step();
    value_in = 10'd456;
    repeat (10) step();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_bcd", {20'd0, bcd_out}, 32'h123);
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step();
      chk("hold_no_second_done", {31'd0, done}, 32'd0);
      chk("hold_no_busy", {31'd0, busy}, 32'd0);
    end
    chk("hold_bcd_kept", {20'd0, bcd_out}, 32'h123);

    // Reset in the 5th SHIFT cycle
    start    = 1'b1;
    value_in = 10'd500;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_bcd",  {20'd0, bcd_out}, 32'h000);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ovf",  {31'd0, overflow}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_no_done", {31'd0, done}, 32'd0);
    end
    run(17, 1'b1);

    // Exhaustive sweep with nibble range checks
    for (int v = 0; v < 1024; v++) begin
      run(v, 1'b0);
      total++;
      assert ((bcd_out[11:8] <= 4'd9) && (bcd_out[7:4] <= 4'd9) && (bcd_out[3:0] <= 4'd9)) else begin
        bad++;
        $error("FAIL nibble_range_%0d observed=%0h expected=digits<=9", v, bcd_out);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_codificador_bcd
